mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, between CPU and RAM.
- Decodes two word addresses in the 10-bit data address space, buffers written bytes in a FIFO and serialises them 8N1 on pin TX.
- All other addresses pass through to RAM unchanged, so the rest of the map is unaffected.

Parameters:
- CLK_DIV, 16: CLK cycles per serial bit (≥2).
- FIFO_DEPTH, 8: TX FIFO entries (power of two).
- TX_ADDR, 10'h3F0: data register address (write only).
- STATUS_ADDR, 10'h3F1: status register address (read; write clears flags).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- RAM_ADDR  in  10  CPU data address.
- RAM_WRITE_DATA  in  32  CPU write data.
- RAM_WRITE_ENABLE  in  1  CPU write strobe.
- RAM_READ_DATA_IN  in  32  read data from RAM.
- RAM_READ_DATA_OUT  out  32  read data to CPU (muxed).
- RAM_WRITE_ENABLE_OUT  out  1  write strobe to RAM (gated).
- TX  out  1  serial line, idle high.
- BUSY  out  1  high while a frame is in progress or the FIFO is non-empty.
- OVERFLOW  out  1  sticky: a byte was dropped.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: TX=1, BUSY=0, OVERFLOW=0, FIFO empty, FSM=IDLE, bit and baud counters 0.
- Reset mid-frame: the frame is aborted, TX=1 after the reset edge, and the FIFO is flushed.
- Address decode (combinational):
  - RAM_WRITE_ENABLE_OUT = RAM_WRITE_ENABLE & (RAM_ADDR≠TX_ADDR) & (RAM_ADDR≠STATUS_ADDR).
  - RAM_READ_DATA_OUT = status word when RAM_ADDR==STATUS_ADDR, 32'h0 when RAM_ADDR==TX_ADDR, else RAM_READ_DATA_IN.
- Status word: bit0 fifo_full, bit1 fifo_empty, bit2 BUSY, bit3 OVERFLOW, bits[7:4] FIFO count (saturates at 15), other bits 0.
- Push rule:
  - A write to TX_ADDR at an edge pushes RAM_WRITE_DATA[7:0]; bits [31:8] are ignored.
  - If the FIFO is full and no pop occurs at the same edge, the byte is dropped and OVERFLOW is set.
  - A push and a pop at the same edge on a full FIFO are both accepted.
- Clear rule: a write to STATUS_ADDR with data bit3=1 clears OVERFLOW. An overflow at the same edge wins (OVERFLOW stays 1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at an edge, pop into the shift register, TX←0, go to START.
  - START: hold TX=0 for CLK_DIV cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, each for CLK_DIV cycles, then go to STOP.
  - STOP: hold TX=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- Latency and frame length:
  - A push at edge N drives TX low after edge N+1.
  - A frame is exactly 10·CLK_DIV cycles.
- Baud counter: counts 0..CLK_DIV-1, reloaded on each state or bit change; width clog2(CLK_DIV).
- BUSY = (FSM≠IDLE) | ~fifo_empty, registered.

Decomposition:
- Package uart_pkg holds the FSM state encoding, status bit indices, and default TX_ADDR and STATUS_ADDR.
- Sub-module tx_fifo: synchronous FIFO with push, pop, full, empty and count outputs, parameterised by width 8 and FIFO_DEPTH, with wrap-around pointers plus an occupancy counter.
- The top level holds the decode, the flags and the FSM.

Test Plan (CLK_DIV=4, FIFO_DEPTH=8):
1. Hold RST high 2 cycles, release -> TX=1, BUSY=0, OVERFLOW=0; read at 10'h3F1 returns 32'h2.
2. Write 32'hABCD_0055 to 10'h3F0 at edge N -> RAM_WRITE_ENABLE_OUT=0; TX=0 for cycles N+1..N+4; then bits 1,0,1,0,1,0,1,0 for 4 cycles each; stop bit 1; BUSY falls 40 cycles after edge N+1.
3. Write bytes 0x01..0x0A to 10'h3F0 on 10 consecutive edges -> 0x0A dropped, OVERFLOW=1, status bit3=1; bytes 0x01..0x09 are sent back-to-back with no gap (9·40 cycles), then BUSY=0.
4. After test 3, write 32'h8 to 10'h3F1 -> OVERFLOW=0 next cycle; RAM_WRITE_ENABLE_OUT=0 throughout.
5. Write 32'h1234 to 10'h010 -> RAM_WRITE_ENABLE_OUT=1 that cycle, FIFO count unchanged; read at 10'h010 returns RAM_READ_DATA_IN.
6. Push 3 bytes, assert RST during DATA of the first frame -> TX=1 after the reset edge, FIFO empty, no further frames, status read = 32'h2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// status-word layout and default register addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;

  localparam logic [9:0] DEF_TX_ADDR     = 10'h3F0;
  localparam logic [9:0] DEF_STATUS_ADDR = 10'h3F1;

  // Status count field is 4 bits wide; deeper FIFOs report 15 when fuller.
  function automatic logic [3:0] sat_count(input int unsigned n);
    if (n > 15) return 4'hF;
    return 4'(n);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with first-word-fall-through read data, wrap-around
// pointers and an occupancy counter.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  // A push into a full FIFO is still taken when a pop frees a slot this edge.
  assign push_ok  = push & (~full | pop);
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting between CPU and RAM: decodes the
// data/status registers, buffers bytes in a FIFO and serialises them on TX.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [9:0]  TX_ADDR     = DEF_TX_ADDR,
  parameter logic [9:0]  STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [9:0]  RAM_ADDR,
  input  logic [31:0] RAM_WRITE_DATA,
  input  logic        RAM_WRITE_ENABLE,
  input  logic [31:0] RAM_READ_DATA_IN,
  output logic [31:0] RAM_READ_DATA_OUT,
  output logic        RAM_WRITE_ENABLE_OUT,
  output logic        TX,
  output logic        BUSY,
  output logic        OVERFLOW
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  tx_state_e     state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_idx, bit_d;
  logic [7:0]    shreg, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q;

  logic          sel_tx, sel_stat, wr_tx, wr_stat;
  logic          pop, push_ok, ovf_set, ovf_clr, baud_end;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_nx;
  logic [7:0]    fifo_rdata;
  logic [31:0]   status;
  logic          unused_wdata;

  assign sel_tx   = (RAM_ADDR == TX_ADDR);
  assign sel_stat = (RAM_ADDR == STATUS_ADDR);
  assign wr_tx    = RAM_WRITE_ENABLE & sel_tx;
  assign wr_stat  = RAM_WRITE_ENABLE & sel_stat;
  assign RAM_WRITE_ENABLE_OUT = RAM_WRITE_ENABLE & ~sel_tx & ~sel_stat;
  assign unused_wdata = ^RAM_WRITE_DATA[31:8];

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (wr_tx),
    .push_data (RAM_WRITE_DATA[7:0]),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_ok  = wr_tx & (~fifo_full | pop);
  assign ovf_set  = wr_tx & fifo_full & ~pop;
  assign ovf_clr  = wr_stat & RAM_WRITE_DATA[3];
  assign count_nx = fifo_count + CW'(push_ok) - CW'(pop);
  assign baud_end = (baud == BAUD_LAST);

  always_comb begin
    status                      = '0;
    status[STAT_FULL]           = fifo_full;
    status[STAT_EMPTY]          = fifo_empty;
    status[STAT_BUSY]           = busy_q;
    status[STAT_OVF]            = ovf_q;
    status[STAT_CNT_LSB +: 4]   = sat_count(32'(fifo_count));
  end

  always_comb begin
    RAM_READ_DATA_OUT = RAM_READ_DATA_IN;
    if (sel_stat)    RAM_READ_DATA_OUT = status;
    else if (sel_tx) RAM_READ_DATA_OUT = '0;
  end

  always_comb begin
    state_d = state;
    baud_d  = baud + 1'b1;
    bit_d   = bit_idx;
    shreg_d = shreg;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_idx + 1'b1;
            tx_d    = shreg[0];
            shreg_d = shreg >> 1;
          end
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered from next-cycle values so BUSY tracks state and FIFO without lag.
    busy_d = (state_d != ST_IDLE) | (count_nx != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  RAM_ADDR;
  logic [31:0] RAM_WRITE_DATA;
  logic        RAM_WRITE_ENABLE;
  logic [31:0] RAM_READ_DATA_IN;
  logic [31:0] RAM_READ_DATA_OUT;
  logic        RAM_WRITE_ENABLE_OUT;
  logic        TX;
  logic        BUSY;
  logic        OVERFLOW;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mmio_uart_tx #(
    .CLK_DIV     (4),
    .FIFO_DEPTH  (8),
    .TX_ADDR     (10'h3F0),
    .STATUS_ADDR (10'h3F1)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .RAM_ADDR             (RAM_ADDR),
    .RAM_WRITE_DATA       (RAM_WRITE_DATA),
    .RAM_WRITE_ENABLE     (RAM_WRITE_ENABLE),
    .RAM_READ_DATA_IN     (RAM_READ_DATA_IN),
    .RAM_READ_DATA_OUT    (RAM_READ_DATA_OUT),
    .RAM_WRITE_ENABLE_OUT (RAM_WRITE_ENABLE_OUT),
    .TX                   (TX),
    .BUSY                 (BUSY),
    .OVERFLOW             (OVERFLOW)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus(input logic [9:0] a, input logic [31:0] d, input logic we);
    RAM_ADDR         = a;
    RAM_WRITE_DATA   = d;
    RAM_WRITE_ENABLE = we;
    #1;
  endtask

  // Line level c cycles after the start bit began: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned c);
    int unsigned k;
    k = c / 4;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic check_frame(input logic [7:0] b, input int unsigned first);
    for (int unsigned c = first; c < 40; c++) begin
      check($sformatf("frame_%02h_c%0d", b, c), {30'b0, BUSY, TX}, {30'b0, 1'b1, frame_bit(b, c)});
      tick();
    end
  endtask

  initial begin
    RST              = 1'b1;
    RAM_ADDR         = 10'h000;
    RAM_WRITE_DATA   = '0;
    RAM_WRITE_ENABLE = 1'b0;
    RAM_READ_DATA_IN = 32'h5A5A_5A5A;

    // 1: reset
    tick();
    tick();
    RST = 1'b0;
    bus(10'h3F1, 32'h0, 1'b0);
    check("rst_tx", {31'b0, TX}, 32'd1);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    check("rst_ovf", {31'b0, OVERFLOW}, 32'd0);
    check("rst_status", RAM_READ_DATA_OUT, 32'h2);

    // 2: single byte 0x55
    bus(10'h3F0, 32'hABCD_0055, 1'b1);
    check("tx_wr_gate", {31'b0, RAM_WRITE_ENABLE_OUT}, 32'd0);
    check("tx_rd_zero", RAM_READ_DATA_OUT, 32'h0);
    tick();
    bus(10'h000, 32'h0, 1'b0);
    check("push_tx_idle", {31'b0, TX}, 32'd1);
    check("push_busy", {31'b0, BUSY}, 32'd1);
    tick();
    check_frame(8'h55, 0);
    check("single_busy_end", {31'b0, BUSY}, 32'd0);
    check("single_tx_end", {31'b0, TX}, 32'd1);

    // 3: ten pushes into an 8-deep FIFO while the first byte starts sending
    for (int unsigned i = 1; i <= 10; i++) begin
      bus(10'h3F0, 32'hFFFF_FF00 | i, 1'b1);
      tick();
    end
    bus(10'h3F1, 32'h0, 1'b0);
    check("ovf_flag", {31'b0, OVERFLOW}, 32'd1);
    check("ovf_status", RAM_READ_DATA_OUT, 32'h8D);
    bus(10'h000, 32'h0, 1'b0);
    check_frame(8'h01, 8);
    for (int unsigned i = 2; i <= 9; i++) check_frame(8'(i), 0);
    check("burst_busy_end", {31'b0, BUSY}, 32'd0);
    check("burst_tx_end", {31'b0, TX}, 32'd1);
    check("burst_ovf_held", {31'b0, OVERFLOW}, 32'd1);

    // 4: clearing OVERFLOW needs bit3
    bus(10'h3F1, 32'h7, 1'b1);
    check("clr7_wr_gate", {31'b0, RAM_WRITE_ENABLE_OUT}, 32'd0);
    tick();
    check("clr7_ovf_kept", {31'b0, OVERFLOW}, 32'd1);
    bus(10'h3F1, 32'h8, 1'b1);
    check("clr8_wr_gate", {31'b0, RAM_WRITE_ENABLE_OUT}, 32'd0);
    tick();
    bus(10'h3F1, 32'h0, 1'b0);
    check("clr8_ovf", {31'b0, OVERFLOW}, 32'd0);
    check("clr8_status", RAM_READ_DATA_OUT, 32'h2);

    // 5: pass-through to RAM
    bus(10'h010, 32'h1234, 1'b1);
    check("ram_wr_pass", {31'b0, RAM_WRITE_ENABLE_OUT}, 32'd1);
    tick();
    bus(10'h3F1, 32'h0, 1'b0);
    check("ram_wr_fifo", RAM_READ_DATA_OUT, 32'h2);
    RAM_READ_DATA_IN = 32'hCAFE_F00D;
    bus(10'h010, 32'h0, 1'b0);
    check("ram_rd_pass", RAM_READ_DATA_OUT, 32'hCAFE_F00D);
    check("ram_idle_busy", {31'b0, BUSY}, 32'd0);

    // 6: reset in the middle of a frame
    bus(10'h3F0, 32'h11, 1'b1);
    tick();
    bus(10'h3F0, 32'h22, 1'b1);
    tick();
    bus(10'h3F0, 32'h33, 1'b1);
    tick();
    bus(10'h000, 32'h0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) tick();
    check("mid_data_bit", {31'b0, TX}, {31'b0, frame_bit(8'h11, 6)});
    check("mid_busy", {31'b0, BUSY}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus(10'h3F1, 32'h0, 1'b0);
    check("abort_tx", {31'b0, TX}, 32'd1);
    check("abort_busy", {31'b0, BUSY}, 32'd0);
    check("abort_status", RAM_READ_DATA_OUT, 32'h2);
    for (int unsigned i = 0; i < 50; i++) begin
      tick();
      check($sformatf("abort_quiet_%0d", i), {30'b0, BUSY, TX}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
